mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, bus word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, storage words; power of two, >= 4.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 The block SHALL have port address, input, DATA_WIDTH, byte address from the core.
REQ-006 The block SHALL have port w_data, input, DATA_WIDTH, write data.
REQ-007 The block SHALL have port r_data, output, DATA_WIDTH, registered read data.
REQ-008 The block SHALL have port csn, input, 1, chip select, active-low.
REQ-009 The block SHALL have port wen, input, 1, write enable, active-low; 1 selects read.
REQ-010 The block SHALL have port busy, output, 1, high while self-clear runs.
REQ-011 The block SHALL have port addr_err, output, 1, one-cycle pulse on a rejected access.

Function
REQ-012 The block SHALL be the responder end of the core's csn/wen memory bus: one access per cycle, no stall input to the core.
REQ-013 The block SHALL implement a state machine with states INIT, IDLE and ERR.
REQ-014 INIT SHALL write 0 to word clr_ptr each cycle, clr_ptr counting 0..DEPTH-1; after word DEPTH-1 it SHALL go to IDLE, so INIT lasts exactly DEPTH cycles.
REQ-015 In INIT, busy SHALL be 1, bus accesses SHALL be ignored (no write, no addr_err), and r_data SHALL hold 0.
REQ-016 In IDLE, an access is csn=0; word index = address[log2(DEPTH)+1:2].
REQ-017 A valid access SHALL have address[1:0]=0 and address < 4*DEPTH; any other access SHALL be rejected.
REQ-018 A valid write (csn=0, wen=0) SHALL update the indexed word at the clock edge; r_data SHALL be unchanged.
REQ-019 A valid read (csn=0, wen=1) SHALL present the indexed word on r_data one cycle later (latency 1).
REQ-020 Read-after-write to the same word in consecutive cycles SHALL return the newly written value.
REQ-021 csn=1 SHALL leave storage and r_data unchanged.
REQ-022 A rejected access SHALL drop any write, set r_data to 0, and go to ERR for one cycle.
REQ-023 In ERR, addr_err SHALL be 1 for that cycle; the access presented in that cycle SHALL be served as in IDLE, and the state SHALL return to IDLE (or stay in ERR if that access is also rejected).
REQ-024 Back-to-back rejected accesses SHALL hold addr_err high for one cycle per rejected access.

Reset
REQ-025 While rst=1, the state SHALL be INIT, clr_ptr 0, r_data 0, busy 1 and addr_err 0.
REQ-026 rst asserted mid-clear or mid-access SHALL restart the clear from word 0, and any in-flight access SHALL be dropped.
REQ-027 Storage contents SHALL only be guaranteed after INIT completes.

Configuration
REQ-028 The macro MEM_RESPONDER_STATS_EN, when defined, SHALL add outputs rd_count and wr_count, each 32 bits.
REQ-029 With MEM_RESPONDER_STATS_EN defined, rd_count and wr_count SHALL count valid reads and writes respectively, wrap modulo 2^32, and be cleared by rst.
REQ-030 Without MEM_RESPONDER_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Release rst, DEPTH=16 -> busy=1 for exactly 16 cycles then 0; reads of words 0..15 return 0.
REQ-032 Write 0xDEADBEEF to 0x8, then read 0x8 the next cycle -> r_data=0xDEADBEEF one cycle after the read, addr_err=0.
REQ-033 Write to 0x6 (misaligned), and read 0x40 with DEPTH=16 -> addr_err pulses once per access; word 1 unchanged; r_data=0.
REQ-034 Assert rst when clr_ptr=7, hold 1 cycle -> busy stays 1 for a further DEPTH cycles; a prior write to 0x4 reads back as 0.
REQ-035 csn=0 with wen=0 applied during INIT -> no addr_err; word unchanged (0) after INIT.
REQ-036 With MEM_RESPONDER_STATS_EN: 3 valid writes, 2 valid reads, 1 rejected read -> wr_count=3, rd_count=2.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory on the core's csn/wen bus: self-clears on reset, flags rejected accesses.
// Define MEM_RESPONDER_STATS_EN to add the rd_count/wr_count access counters.
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  input  logic                  csn,
  input  logic                  wen,
  output logic                  busy,
  output logic                  addr_err
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, ERR} state_t;

  state_t                state;
  logic [AW-1:0]         clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         idx;
  logic                  valid;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DATA_WIDTH-1:0] wdata;

  assign idx   = address[AW+1:2];
  // Word-aligned and below 4*DEPTH: every bit above the index field must be zero.
  assign valid = (address[1:0] == 2'b00) && ((address >> (AW + 2)) == '0);

  // One write port shared by the clear sweep and bus writes.
  always_comb begin
    we    = 1'b0;
    waddr = clr_ptr;
    wdata = '0;
    if (!rst) begin
      if (state == INIT) begin
        we = 1'b1;
      end else if (!csn && !wen && valid) begin
        we    = 1'b1;
        waddr = idx;
        wdata = w_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      clr_ptr  <= '0;
      r_data   <= '0;
      busy     <= 1'b1;
      addr_err <= 1'b0;
`ifdef MEM_RESPONDER_STATS_EN
      rd_count <= '0;
      wr_count <= '0;
`endif
    end else begin
      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          // IDLE and ERR serve the bus identically; ERR only differs in addr_err.
          state    <= IDLE;
          addr_err <= 1'b0;
          if (!csn) begin
            if (valid) begin
              if (wen) begin
                r_data <= mem[idx];
`ifdef MEM_RESPONDER_STATS_EN
                rd_count <= rd_count + 32'd1;
`endif
              end else begin
`ifdef MEM_RESPONDER_STATS_EN
                wr_count <= wr_count + 32'd1;
`endif
              end
            end else begin
              r_data   <= '0;
              state    <= ERR;
              addr_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=16): clear timing, read/write, rejects, mid-clear reset.
module tb_mem_responder;

  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] address;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          csn;
  logic          wen;
  logic          busy;
  logic          addr_err;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
`endif

  int checks = 0;
  int errors = 0;

  mem_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .w_data   (w_data),
    .r_data   (r_data),
    .csn      (csn),
    .wen      (wen),
    .busy     (busy),
    .addr_err (addr_err)
`ifdef MEM_RESPONDER_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    csn = 1'b1;
    wen = 1'b1;
    address = '0;
    w_data = '0;
  endtask

  task automatic bus_write(input logic [DW-1:0] a, input logic [DW-1:0] d);
    csn = 1'b0; wen = 1'b0; address = a; w_data = d;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [DW-1:0] a);
    csn = 1'b0; wen = 1'b1; address = a; w_data = '0;
    step();
    bus_idle();
  endtask

  // Steps until busy drops; returns cycles spent busy after rst release.
  task automatic wait_init(output int n, output bit saw_err);
    n = 0;
    saw_err = 0;
    while (busy && n < 100) begin
      step();
      n++;
      if (addr_err) saw_err = 1;
    end
  endtask

  task automatic test_reset();
    int  n;
    bit  saw_err;
    bit  bad;
    bus_idle();
    // Access presented while in reset must be dropped.
    rst = 1'b1; csn = 1'b0; wen = 1'b0; address = 32'h4; w_data = 32'hFFFF_FFFF;
    step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
    checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL reset_r_data got=%h exp=0", r_data); end
    // Keep writing 0x4 through INIT: must be ignored.
    rst = 1'b0;
    wait_init(n, saw_err);
    bus_idle();
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL init_len got=%0d exp=%0d", n, DEPTH); end
    checks++; if (saw_err !== 1'b0) begin errors++; $display("FAIL init_addr_err got=%b exp=0", saw_err); end
    checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL init_r_data got=%h exp=0", r_data); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(32'(i * 4));
      if (r_data !== 32'h0 || addr_err !== 1'b0) begin
        bad = 1;
        $display("FAIL clear_word%0d got=%h exp=0", i, r_data);
      end
    end
    checks++; if (bad) errors++;
  endtask

  task automatic test_write_read();
    bus_write(32'h8, 32'hDEAD_BEEF);
    checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL wr_keeps_r_data got=%h exp=0", r_data); end
    bus_read(32'h8);
    checks++; if (r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_word2 got=%h exp=deadbeef", r_data); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL raw_addr_err got=%b exp=0", addr_err); end
    bus_write(32'h4, 32'h1111_1111);
    bus_write(32'h3C, 32'hA5A5_0F0F);
    bus_read(32'h3C);
    checks++; if (r_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL top_word got=%h exp=a5a50f0f", r_data); end
    bus_read(32'h4);
    checks++; if (r_data !== 32'h1111_1111) begin errors++; $display("FAIL word1 got=%h exp=11111111", r_data); end
    step();
    checks++; if (r_data !== 32'h1111_1111) begin errors++; $display("FAIL csn_hold got=%h exp=11111111", r_data); end
  endtask

  task automatic test_reject();
    bus_write(32'h6, 32'h1234_5678);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL misaligned_err got=%b exp=1", addr_err); end
    checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL misaligned_r_data got=%h exp=0", r_data); end
    step();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", addr_err); end
    // Two rejected reads back to back, then a valid read served while in ERR.
    bus_read(32'h40);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL range_err1 got=%b exp=1", addr_err); end
    bus_read(32'h40);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL range_err2 got=%b exp=1", addr_err); end
    checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL range_r_data got=%h exp=0", r_data); end
    bus_read(32'h4);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_exit got=%b exp=0", addr_err); end
    checks++; if (r_data !== 32'h1111_1111) begin errors++; $display("FAIL word1_intact got=%h exp=11111111", r_data); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit saw_err;
    rst = 1'b1; step(); rst = 1'b0;
    repeat (7) step();   // clear pointer now at 7
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    wait_init(n, saw_err);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL midrst_len got=%0d exp=%0d", n, DEPTH); end
    bus_read(32'h4);
    checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL midrst_word1 got=%h exp=0", r_data); end
  endtask

`ifdef MEM_RESPONDER_STATS_EN
  task automatic test_stats();
    int n;
    bit saw_err;
    rst = 1'b1; step(); rst = 1'b0;
    wait_init(n, saw_err);
    checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin errors++; $display("FAIL stats_reset rd=%0d wr=%0d exp=0", rd_count, wr_count); end
    bus_write(32'h0, 32'h1);
    bus_write(32'h4, 32'h2);
    bus_write(32'h8, 32'h3);
    bus_read(32'h4);
    bus_read(32'h44);
    bus_read(32'h8);
    checks++; if (wr_count !== 32'd3) begin errors++; $display("FAIL stats_wr got=%0d exp=3", wr_count); end
    checks++; if (rd_count !== 32'd2) begin errors++; $display("FAIL stats_rd got=%0d exp=2", rd_count); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus_idle();
    test_reset();
    test_write_read();
    test_reject();
    test_reset_mid_clear();
`ifdef MEM_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
